// File: rtl/bp_vcache_ctrl.sv
// Victim cache between the D$ engine and the UCE memory path: captures evicted
// blocks, services miss lookups, and writes dirty victims back on reclaim or flush.
module bp_vcache_ctrl #(
    parameter int unsigned paddr_width_p = 40,
    parameter int unsigned block_width_p = 512,
    parameter int unsigned entries_p     = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     evict_v_i,
    input  logic [paddr_width_p-1:0] evict_addr_i,
    input  logic [block_width_p-1:0] evict_data_i,
    input  logic                     evict_dirty_i,
    output logic                     evict_ready_o,

    input  logic                     lookup_v_i,
    input  logic [paddr_width_p-1:0] lookup_addr_i,
    output logic                     lookup_ready_o,
    output logic                     lookup_resp_v_o,
    output logic                     lookup_hit_o,
    output logic [block_width_p-1:0] lookup_data_o,
    output logic                     lookup_dirty_o,
    input  logic                     lookup_resp_yumi_i,

    output logic                     wb_v_o,
    output logic [paddr_width_p-1:0] wb_addr_o,
    output logic [block_width_p-1:0] wb_data_o,
    input  logic                     wb_ready_i,

    input  logic                     flush_v_i,
    output logic                     flush_ready_o,
    output logic                     flush_done_o
);

    localparam int unsigned offset_w_lp = $clog2(block_width_p / 8);
    localparam int unsigned tag_w_lp    = paddr_width_p - offset_w_lp;
    localparam int unsigned idx_w_lp    = $clog2(entries_p);

    typedef enum logic [1:0] {e_ready, e_resp, e_wb, e_flush} state_e;

    state_e                     state_q, state_d;
    logic [entries_p-1:0]       valid_q, valid_d;
    logic [entries_p-1:0]       dirty_q, dirty_d;
    logic [tag_w_lp-1:0]        tag_q  [entries_p];
    logic [tag_w_lp-1:0]        tag_d  [entries_p];
    logic [block_width_p-1:0]   data_q [entries_p];
    logic [block_width_p-1:0]   data_d [entries_p];
    logic [idx_w_lp-1:0]        rr_q, rr_d;
    logic [idx_w_lp-1:0]        wb_idx_q, wb_idx_d;
    logic [idx_w_lp-1:0]        flush_idx_q, flush_idx_d;
    logic                       resp_v_q, resp_v_d;
    logic                       resp_hit_q, resp_hit_d;
    logic                       resp_dirty_q, resp_dirty_d;
    logic [block_width_p-1:0]   resp_data_q, resp_data_d;
    logic                       flush_done_q, flush_done_d;

    logic [tag_w_lp-1:0] lk_tag, ev_tag;
    logic                lk_hit, ev_match, has_inv, ev_victim_dirty;
    logic [idx_w_lp-1:0] lk_idx, ev_match_idx, inv_idx, ev_target, wb_sel;
    logic                lookup_acc, evict_go, evict_acc, evict_wb, flush_acc;
    logic                flush_cur_dirty, flush_step, flush_last;
    logic                unused_offset;

    assign lk_tag = lookup_addr_i[paddr_width_p-1:offset_w_lp];
    assign ev_tag = evict_addr_i[paddr_width_p-1:offset_w_lp];
    assign unused_offset = ^{lookup_addr_i[offset_w_lp-1:0], evict_addr_i[offset_w_lp-1:0]};

    // Associative search for the lookup, the evict merge target and the lowest free slot
    always_comb begin
        lk_hit       = 1'b0;
        lk_idx       = '0;
        ev_match     = 1'b0;
        ev_match_idx = '0;
        has_inv      = 1'b0;
        inv_idx      = '0;
        for (int unsigned i = 0; i < entries_p; i++) begin
            if (valid_q[i] && tag_q[i] == lk_tag) begin
                lk_hit = 1'b1;
                lk_idx = idx_w_lp'(i);
            end
            if (valid_q[i] && tag_q[i] == ev_tag) begin
                ev_match     = 1'b1;
                ev_match_idx = idx_w_lp'(i);
            end
        end
        for (int i = int'(entries_p) - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                has_inv = 1'b1;
                inv_idx = idx_w_lp'(i);
            end
        end
    end

    assign ev_target       = ev_match ? ev_match_idx : (has_inv ? inv_idx : rr_q);
    assign ev_victim_dirty = valid_q[ev_target] && dirty_q[ev_target] && (tag_q[ev_target] != ev_tag);

    assign flush_acc  = (state_q == e_ready) && flush_v_i;
    assign lookup_acc = (state_q == e_ready) && !flush_v_i && lookup_v_i;
    assign evict_go   = (state_q == e_ready) && !flush_v_i && !lookup_v_i && evict_v_i;
    assign evict_acc  = evict_go && !ev_victim_dirty;
    assign evict_wb   = evict_go && ev_victim_dirty;

    assign flush_cur_dirty = valid_q[flush_idx_q] && dirty_q[flush_idx_q];
    assign flush_step      = (state_q == e_flush) && (!flush_cur_dirty || wb_ready_i);
    assign flush_last      = flush_idx_q == idx_w_lp'(entries_p - 1);

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= e_ready;
        else         state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            e_ready: begin
                if (flush_acc)       state_d = e_flush;
                else if (lookup_acc) state_d = e_resp;
                else if (evict_wb)   state_d = e_wb;
            end
            e_resp:  if (lookup_resp_yumi_i)        state_d = e_ready;
            e_wb:    if (wb_ready_i)                state_d = e_ready;
            e_flush: if (flush_step && flush_last)  state_d = e_ready;
            default: state_d = e_ready;
        endcase
    end

    // Handshake and writeback outputs
    always_comb begin
        flush_ready_o  = 1'b0;
        lookup_ready_o = 1'b0;
        evict_ready_o  = 1'b0;
        wb_v_o         = 1'b0;
        wb_sel         = wb_idx_q;
        unique case (state_q)
            e_ready: begin
                flush_ready_o  = 1'b1;
                lookup_ready_o = !flush_v_i;
                evict_ready_o  = !flush_v_i && !lookup_v_i && !ev_victim_dirty;
            end
            e_wb:    wb_v_o = 1'b1;
            e_flush: begin
                wb_v_o = flush_cur_dirty;
                wb_sel = flush_idx_q;
            end
            default: ;
        endcase
        wb_addr_o = wb_v_o ? {tag_q[wb_sel], {offset_w_lp{1'b0}}} : '0;
        wb_data_o = wb_v_o ? data_q[wb_sel] : '0;
    end

    // Entry and response updates
    always_comb begin
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        tag_d        = tag_q;
        data_d       = data_q;
        rr_d         = rr_q;
        wb_idx_d     = wb_idx_q;
        flush_idx_d  = flush_idx_q;
        resp_v_d     = resp_v_q;
        resp_hit_d   = resp_hit_q;
        resp_dirty_d = resp_dirty_q;
        resp_data_d  = resp_data_q;
        flush_done_d = 1'b0;

        if (lookup_acc) begin
            resp_v_d     = 1'b1;
            resp_hit_d   = lk_hit;
            resp_dirty_d = lk_hit && dirty_q[lk_idx];
            resp_data_d  = lk_hit ? data_q[lk_idx] : '0;
            if (lk_hit) begin
                valid_d[lk_idx] = 1'b0;
                dirty_d[lk_idx] = 1'b0;
            end
        end
        if (state_q == e_resp && lookup_resp_yumi_i) begin
            resp_v_d     = 1'b0;
            resp_hit_d   = 1'b0;
            resp_dirty_d = 1'b0;
            resp_data_d  = '0;
        end
        if (evict_acc) begin
            valid_d[ev_target] = 1'b1;
            dirty_d[ev_target] = evict_dirty_i || (ev_match && dirty_q[ev_target]);
            tag_d[ev_target]   = ev_tag;
            data_d[ev_target]  = evict_data_i;
            if (!ev_match && !has_inv) rr_d = rr_q + idx_w_lp'(1);
        end
        if (evict_wb) wb_idx_d = ev_target;
        // Reclaimed slot becomes free; the pending evict lands there next cycle
        if (state_q == e_wb && wb_ready_i) begin
            valid_d[wb_idx_q] = 1'b0;
            dirty_d[wb_idx_q] = 1'b0;
        end
        if (flush_acc) flush_idx_d = '0;
        if (flush_step) begin
            valid_d[flush_idx_q] = 1'b0;
            dirty_d[flush_idx_q] = 1'b0;
            if (flush_last) begin
                flush_done_d = 1'b1;
                rr_d         = '0;
                flush_idx_d  = '0;
            end else begin
                flush_idx_d = flush_idx_q + idx_w_lp'(1);
            end
        end
    end

    // Control and metadata registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q      <= '0;
            dirty_q      <= '0;
            rr_q         <= '0;
            wb_idx_q     <= '0;
            flush_idx_q  <= '0;
            resp_v_q     <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_dirty_q <= 1'b0;
            resp_data_q  <= '0;
            flush_done_q <= 1'b0;
            for (int unsigned i = 0; i < entries_p; i++) tag_q[i] <= '0;
        end else begin
            valid_q      <= valid_d;
            dirty_q      <= dirty_d;
            rr_q         <= rr_d;
            wb_idx_q     <= wb_idx_d;
            flush_idx_q  <= flush_idx_d;
            resp_v_q     <= resp_v_d;
            resp_hit_q   <= resp_hit_d;
            resp_dirty_q <= resp_dirty_d;
            resp_data_q  <= resp_data_d;
            flush_done_q <= flush_done_d;
            tag_q        <= tag_d;
        end
    end

    // Block data storage is qualified by valid and needs no reset
    always_ff @(posedge clk_i) begin
        data_q <= data_d;
    end

    assign lookup_resp_v_o = resp_v_q;
    assign lookup_hit_o    = resp_hit_q;
    assign lookup_dirty_o  = resp_dirty_q;
    assign lookup_data_o   = resp_data_q;
    assign flush_done_o    = flush_done_q;

endmodule
